// File: rtl/shop_pkg.sv
// Shared types and default widths for the shop inventory controller and the
// per-session command-parser FSMs that talk to it.
package shop_pkg;

    localparam int unsigned DEF_NUM_REQ    = 4;
    localparam int unsigned DEF_ITEM_BITS  = 3;
    localparam int unsigned DEF_STOCK_BITS = 8;
    localparam int unsigned SOLD_BITS      = 16;

    typedef enum logic [1:0] {
        OP_QUERY  = 2'b00,
        OP_ADD    = 2'b01,
        OP_BUY    = 2'b10,
        OP_DELETE = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_OK     = 2'b00,
        ST_INSUFF = 2'b01,
        ST_OVF    = 2'b10,
        ST_RSVD   = 2'b11
    } status_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_DONE = 2'b10
    } state_e;

    // Index width for an n-entry one-hot vector (at least one bit).
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/shop_rr_arbiter.sv
// Round-robin arbiter: search starts one past the last winner; the pointer
// advances only when the caller commits a grant through update.
module shop_rr_arbiter
    import shop_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    localparam int unsigned IDX_W  = idx_width(NUM_REQ)
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               update,
    output logic [NUM_REQ-1:0] gnt_c,
    output logic [IDX_W-1:0]   idx_c,
    output logic               any_c
);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] cand;
    int unsigned      pos;

    // First requester at or after the pointer, wrapping modulo NUM_REQ.
    always_comb begin
        gnt_c = '0;
        idx_c = '0;
        any_c = 1'b0;
        cand  = '0;
        pos   = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            pos  = (32'(ptr_q) + i) % NUM_REQ;
            cand = IDX_W'(pos);
            if (!any_c && req[cand]) begin
                any_c       = 1'b1;
                idx_c       = cand;
                gnt_c[cand] = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            ptr_q <= '0;
        end else if (update && any_c) begin
            if (32'(idx_c) == NUM_REQ - 1) begin
                ptr_q <= '0;
            end else begin
                ptr_q <= idx_c + IDX_W'(1);
            end
        end
    end

endmodule

// File: rtl/shop_inventory_ctrl.sv
// Item-stock store with a serialising round-robin access controller: one atomic
// read-modify-write per granted transaction. Optional macro SHOP_INV_SOLD_CNT_EN adds o_sold_total.
module shop_inventory_ctrl
    import shop_pkg::*;
#(
    parameter int unsigned NUM_REQ    = DEF_NUM_REQ,
    parameter int unsigned ITEM_BITS  = DEF_ITEM_BITS,
    parameter int unsigned STOCK_BITS = DEF_STOCK_BITS
) (
    input  logic                           i_clk,
    input  logic                           i_reset,
    input  logic [NUM_REQ-1:0]             i_req,
    input  logic [2*NUM_REQ-1:0]           i_op,
    input  logic [ITEM_BITS*NUM_REQ-1:0]   i_item,
    input  logic [STOCK_BITS*NUM_REQ-1:0]  i_qty,
    output logic [NUM_REQ-1:0]             o_gnt,
    output logic [NUM_REQ-1:0]             o_done,
    output logic [1:0]                     o_status,
    output logic [STOCK_BITS-1:0]          o_stock
`ifdef SHOP_INV_SOLD_CNT_EN
    ,
    output logic [SOLD_BITS-1:0]           o_sold_total
`endif
);

    localparam int unsigned IDX_W  = idx_width(NUM_REQ);
    localparam int unsigned SLOTS  = 2 ** ITEM_BITS;
    localparam int unsigned CALC_W = STOCK_BITS + 1;

    state_e                  state_q;
    state_e                  state_d;
    logic [NUM_REQ-1:0]      gnt_d;
    logic [NUM_REQ-1:0]      done_d;

    logic [NUM_REQ-1:0]      arb_gnt_c;
    logic [IDX_W-1:0]        arb_idx_c;
    logic                    arb_any_c;
    logic                    arb_update_c;

    op_e                     sel_op_c;
    logic [ITEM_BITS-1:0]    sel_item_c;
    logic [STOCK_BITS-1:0]   sel_qty_c;

    op_e                     op_q;
    logic [ITEM_BITS-1:0]    item_q;
    logic [STOCK_BITS-1:0]   qty_q;

    logic [STOCK_BITS-1:0]   stock_mem [SLOTS];

    logic [STOCK_BITS-1:0]   cur_c;
    logic [CALC_W-1:0]       sum_c;
    logic [CALC_W-1:0]       diff_c;
    logic [STOCK_BITS-1:0]   res_c;
    status_e                 status_c;
    logic                    wr_c;

    assign arb_update_c = (state_q == S_IDLE);

    shop_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .req     (i_req),
        .update  (arb_update_c),
        .gnt_c   (arb_gnt_c),
        .idx_c   (arb_idx_c),
        .any_c   (arb_any_c)
    );

    // Pick the winning requester's operand slices.
    always_comb begin
        sel_op_c   = OP_QUERY;
        sel_item_c = '0;
        sel_qty_c  = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (32'(arb_idx_c) == k) begin
                sel_op_c   = op_e'(i_op[2*k +: 2]);
                sel_item_c = i_item[ITEM_BITS*k +: ITEM_BITS];
                sel_qty_c  = i_qty[STOCK_BITS*k +: STOCK_BITS];
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus next grant/done; o_gnt itself holds the latched winner.
    always_comb begin
        state_d = state_q;
        gnt_d   = o_gnt;
        done_d  = '0;
        unique case (state_q)
            S_IDLE: begin
                if (arb_any_c) begin
                    state_d = S_EXEC;
                    gnt_d   = arb_gnt_c;
                end
            end
            S_EXEC: begin
                state_d = S_DONE;
                done_d  = o_gnt;
            end
            S_DONE: begin
                state_d = S_IDLE;
                gnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // Operands are captured only on the grant edge.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            op_q   <= OP_QUERY;
            item_q <= '0;
            qty_q  <= '0;
        end else if (state_q == S_IDLE && arb_any_c) begin
            op_q   <= sel_op_c;
            item_q <= sel_item_c;
            qty_q  <= sel_qty_c;
        end
    end

    // RMW datapath: carry/borrow out of the extra bit rejects the op instead of wrapping.
    always_comb begin
        cur_c    = stock_mem[item_q];
        sum_c    = CALC_W'(cur_c) + CALC_W'(qty_q);
        diff_c   = CALC_W'(cur_c) - CALC_W'(qty_q);
        res_c    = cur_c;
        status_c = ST_OK;
        wr_c     = 1'b0;
        case (op_q)
            OP_ADD: begin
                if (sum_c[STOCK_BITS]) begin
                    status_c = ST_OVF;
                end else begin
                    res_c = sum_c[STOCK_BITS-1:0];
                    wr_c  = 1'b1;
                end
            end
            OP_BUY: begin
                if (diff_c[STOCK_BITS]) begin
                    status_c = ST_INSUFF;
                end else begin
                    res_c = diff_c[STOCK_BITS-1:0];
                    wr_c  = 1'b1;
                end
            end
            OP_DELETE: begin
                res_c = '0;
                wr_c  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int unsigned s = 0; s < SLOTS; s++) begin
                stock_mem[s] <= '0;
            end
        end else if (state_q == S_EXEC && wr_c) begin
            stock_mem[item_q] <= res_c;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_gnt    <= '0;
            o_done   <= '0;
            o_status <= '0;
            o_stock  <= '0;
        end else begin
            o_gnt  <= gnt_d;
            o_done <= done_d;
            if (state_q == S_EXEC) begin
                o_status <= status_c;
                o_stock  <= res_c;
            end
        end
    end

`ifdef SHOP_INV_SOLD_CNT_EN
    localparam int unsigned SOLD_SUM_W = SOLD_BITS + 1;

    logic [SOLD_SUM_W-1:0] sold_sum_c;

    assign sold_sum_c = SOLD_SUM_W'(o_sold_total) + SOLD_SUM_W'(qty_q);

    // Units sold by successful BUYs, pinned at all-ones once full.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_sold_total <= '0;
        end else if (state_q == S_EXEC && op_q == OP_BUY && status_c == ST_OK) begin
            if (sold_sum_c[SOLD_BITS]) begin
                o_sold_total <= '1;
            end else begin
                o_sold_total <= sold_sum_c[SOLD_BITS-1:0];
            end
        end
    end
`endif

endmodule

// File: tb/tb_shop_inventory_ctrl.sv
// Scoreboard bench for shop_inventory_ctrl: a transaction-level stock/RR model
// predicts every completion; a negedge monitor pops and compares.
module tb_shop_inventory_ctrl;

    localparam int NREQ = 4;
    localparam int IB   = 3;
    localparam int SB   = 8;
    localparam int MAXS = (1 << SB) - 1;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req;
    logic [2*NREQ-1:0]    op;
    logic [IB*NREQ-1:0]   item;
    logic [SB*NREQ-1:0]   qty;
    logic [NREQ-1:0]      gnt;
    logic [NREQ-1:0]      done;
    logic [1:0]           status;
    logic [SB-1:0]        stock;
`ifdef SHOP_INV_SOLD_CNT_EN
    logic [15:0]          sold_total;
`endif

    always #5 clk = ~clk;

    shop_inventory_ctrl #(
        .NUM_REQ    (NREQ),
        .ITEM_BITS  (IB),
        .STOCK_BITS (SB)
    ) dut (
        .i_clk    (clk),
        .i_reset  (rst),
        .i_req    (req),
        .i_op     (op),
        .i_item   (item),
        .i_qty    (qty),
        .o_gnt    (gnt),
        .o_done   (done),
        .o_status (status),
        .o_stock  (stock)
`ifdef SHOP_INV_SOLD_CNT_EN
        ,
        .o_sold_total (sold_total)
`endif
    );

    typedef struct {
        logic [NREQ-1:0] done;
        logic [1:0]      st;
        logic [SB-1:0]   stock;
    } exp_t;

    exp_t sb_q[$];

    int m_stock [1 << IB];
    int m_ptr;
    int m_sold;
    int t_op   [NREQ];
    int t_item [NREQ];
    int t_qty  [NREQ];

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int n_done = 0;
    int cont_base = 0;
    int last_done_cyc = 0;
    logic cont_mode = 1'b0;
    logic hold_mode = 1'b0;
    logic [NREQ-1:0] scr;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every completion must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && done != '0) begin
            exp_t e;
            if (cont_mode && n_done > cont_base)
                chk("done_period", 32'(cyc - last_done_cyc), 32'd3);
            last_done_cyc = cyc;
            if (sb_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_done: got done=%b with nothing outstanding", done);
            end else begin
                e = sb_q.pop_front();
                chk("done_vec", 32'(done), 32'(e.done));
                chk("gnt_vec", 32'(gnt), 32'(e.done));
                chk("status", 32'(status), 32'(e.st));
                chk("stock", 32'(stock), 32'(e.stock));
            end
            n_done = n_done + 1;
        end
    end

    task automatic model_reset();
        for (int i = 0; i < (1 << IB); i++) m_stock[i] = 0;
        m_ptr  = 0;
        m_sold = 0;
    endtask

    // Spec-level effect of one transaction by requester k.
    task automatic model_exec(input int k);
        exp_t e;
        int s;
        int q;
        s       = m_stock[t_item[k]];
        q       = t_qty[k];
        e.done  = '0;
        e.done[k] = 1'b1;
        e.st    = 2'b00;
        case (t_op[k])
            0: ;
            1: if (s + q > MAXS) e.st = 2'b10; else s = s + q;
            2: begin
                if (q > s) e.st = 2'b01;
                else begin
                    s = s - q;
                    m_sold = (m_sold + q > 65535) ? 65535 : m_sold + q;
                end
            end
            default: s = 0;
        endcase
        m_stock[t_item[k]] = s;
        e.stock = SB'(s);
        sb_q.push_back(e);
    endtask

    // Serve one requester from the pending mask in round-robin order.
    task automatic serve_one(inout logic [NREQ-1:0] pend);
        for (int i = 0; i < NREQ; i++) begin
            int c;
            c = (m_ptr + i) % NREQ;
            if (pend[c]) begin
                pend[c] = 1'b0;
                m_ptr   = (c + 1) % NREQ;
                model_exec(c);
                break;
            end
        end
    endtask

    task automatic set_op(input int k, input int o, input int it, input int q);
        t_op[k]   = o;
        t_item[k] = it;
        t_qty[k]  = q;
    endtask

    task automatic apply_ops();
        for (int k = 0; k < NREQ; k++) begin
            op[2*k +: 2]    = 2'(t_op[k]);
            item[IB*k +: IB] = IB'(t_item[k]);
            qty[SB*k +: SB]  = SB'(t_qty[k]);
        end
    endtask

    // Advance cycles, dropping each requester at the edge ending its done cycle.
    task automatic run_until_idle(input int budget);
        int n;
        logic [NREQ-1:0] drop;
        n = 0;
        while (!(req == '0 && sb_q.size() == 0)) begin
            if (n >= budget) begin
                n_chk++;
                n_fail++;
                $display("FAIL timeout: req=%b outstanding=%0d after %0d cycles", req, sb_q.size(), n);
                req = '0;
                sb_q.delete();
                break;
            end
            drop = done;
            @(posedge clk);
            #1;
            n++;
            if (hold_mode) begin
                if (n_done - cont_base >= 5) req = '0;
            end else begin
                req = req & ~drop;
                for (int k = 0; k < NREQ; k++) begin
                    if (gnt[k] && !scr[k]) begin
                        op[2*k +: 2]     = 2'($urandom);
                        item[IB*k +: IB] = IB'($urandom);
                        qty[SB*k +: SB]  = SB'($urandom);
                        scr[k] = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic drive_batch(input logic [NREQ-1:0] mask);
        logic [NREQ-1:0] pend;
        pend = mask;
        while (pend != '0) serve_one(pend);
        apply_ops();
        scr = '0;
        req = mask;
        run_until_idle(60);
`ifdef SHOP_INV_SOLD_CNT_EN
        chk("sold_total", 32'(sold_total), 32'(m_sold));
`endif
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_gnt"}, 32'(gnt), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_status"}, 32'(status), 32'd0);
        chk({tag, "_stock"}, 32'(stock), 32'd0);
`ifdef SHOP_INV_SOLD_CNT_EN
        chk({tag, "_sold"}, 32'(sold_total), 32'd0);
`endif
    endtask

    initial begin
        logic [NREQ-1:0] pend;
        rst  = 1'b1;
        req  = '0;
        op   = '0;
        item = '0;
        qty  = '0;
        scr  = '0;
        model_reset();
        for (int k = 0; k < NREQ; k++) set_op(k, 0, 0, 0);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1 rst = 1'b0;

        // Latency: req0 QUERY item 2 right after reset.
        @(posedge clk);
        #1;
        set_op(0, 0, 2, 0);
        pend = 4'b0001;
        serve_one(pend);
        apply_ops();
        req = 4'b0001;
        @(negedge clk);
        chk("gnt_not_yet", 32'(gnt), 32'd0);
        @(negedge clk);
        chk("gnt_latency", 32'(gnt), 32'b0001);
        chk("done_not_yet", 32'(done), 32'd0);
        @(negedge clk);
        chk("done_latency", 32'(done), 32'b0001);
        @(posedge clk);
        #1 req = '0;
        @(negedge clk);
        chk("gnt_cleared", 32'(gnt), 32'd0);
        chk("done_single", 32'(done), 32'd0);
        @(posedge clk);
        #1;

        // ADD overflow on item 5.
        set_op(1, 1, 5, 200); drive_batch(4'b0010);
        set_op(1, 1, 5, 100); drive_batch(4'b0010);

        // Sold-unit accounting: BUY 3 OK, BUY 5 INSUFF, BUY 2 OK.
        set_op(0, 1, 4, 6); drive_batch(4'b0001);
        set_op(2, 2, 4, 3); drive_batch(4'b0100);
        set_op(3, 2, 4, 5); drive_batch(4'b1000);
        set_op(1, 2, 4, 2); drive_batch(4'b0010);
`ifdef SHOP_INV_SOLD_CNT_EN
        chk("sold_directed", 32'(sold_total), 32'd5);
`endif

        // Underflow, exact BUY and DELETE on item 1.
        set_op(2, 1, 1, 10); drive_batch(4'b0100);
        set_op(3, 2, 1, 11); drive_batch(4'b1000);
        set_op(0, 2, 1, 10); drive_batch(4'b0001);
        set_op(1, 3, 1, 0);  drive_batch(4'b0010);
        set_op(2, 1, 1, 0);  drive_batch(4'b0100);

        // Random concurrent batches.
        for (int b = 0; b < 40; b++) begin
            logic [NREQ-1:0] m;
            m = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            for (int k = 0; k < NREQ; k++) begin
                int r;
                int q;
                r = $urandom_range(0, 9);
                q = (r == 0) ? 0 : (r == 1) ? MAXS : $urandom_range(0, 120);
                set_op(k, (r > 6) ? 1 : $urandom_range(0, 3), $urandom_range(0, (1 << IB) - 1), q);
            end
            drive_batch(m);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end

        // Reset in the middle of an ADD: abandoned, no completion, memory cleared.
        set_op(2, 1, 3, 7);
        apply_ops();
        req = 4'b0100;
        @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midreset");
        @(posedge clk);
        #1;
        req = '0;
        rst = 1'b0;
        model_reset();

        // All requesters held high: RR order 0,1,2,3,0 at one completion per 3 cycles.
        set_op(0, 0, 3, 0);
        set_op(1, 1, 3, 7);
        set_op(2, 2, 3, 3);
        set_op(3, 0, 6, 0);
        for (int t = 0; t < 5; t++) begin
            pend = 4'b1111;
            serve_one(pend);
        end
        apply_ops();
        cont_base = n_done;
        cont_mode = 1'b1;
        hold_mode = 1'b1;
        req = 4'b1111;
        run_until_idle(40);
        hold_mode = 1'b0;
        cont_mode = 1'b0;
        chk("cont_count", 32'(n_done - cont_base), 32'd5);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
